modulo_n_updown: RTL and testbench
==================================

// Module: modulo_n_updown
// PURPOSE
//  Run-time programmable modulo counter: up/down counting, synchronous load, start/stop control, one-shot mode.
//  Modulus is a port, not a constant, so one instance covers any modulus 1..2**WIDTH.
//  tc is a cascade carry: it drives ce of the next stage to build multi-digit counters and timers.
// PARAMETERS
//  WIDTH     8      counter width; supported modulus 1..2**WIDTH
//  WCNT_W    16     width of wrap_cnt (only with MODN_WRAP_CNT_EN)
// PORTS
//  clk       in   1      rising-edge clock; single clock domain
//  rst_n     in   1      asynchronous reset, active-low
//  ce        in   1      count enable; one step per cycle while RUN
//  up        in   1      1 = count up, 0 = count down; sampled each enabled cycle
//  mod_last  in   WIDTH  terminal value = modulus-1; may change at any time
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  load data; clamped to mod_last
//  start     in   1      IDLE/DONE -> RUN
//  stop      in   1      any state -> IDLE
//  oneshot   in   1      1 = stop at terminal (DONE); 0 = wrap continuously
//  count     out  WIDTH  current value (registered)
//  tc        out  1      terminal-count carry (combinational, see below)
//  busy      out  1      1 while state == RUN (registered)
//  done      out  1      one-cycle pulse on entry to DONE (registered)
// BEHAVIOUR
//  - Reset (rst_n low, async): count=0, state=IDLE, busy=0, done=0, wrap_cnt=0.
//  - FSM IDLE/RUN/DONE.
//    - stop -> IDLE.
//    - else start in IDLE/DONE -> RUN; start in RUN is ignored.
//    - stop and start in the same cycle: stop wins.
//  - term = up ? (count >= mod_last) : (count == 0 || count > mod_last).
//  - step = RUN & ce & !load & !stop.
//  - tc = step & term, combinational, same cycle as the terminal step.
//  - Step, oneshot=0:
//    - up: term ? 0 : count+1.
//    - down: term ? mod_last : count-1.
//  - Step, oneshot=1 with term:
//    - count does not wrap: holds (up) or loads mod_last if count > mod_last (down).
//    - next state DONE; done=1 for exactly one cycle.
//  - Non-terminal step, oneshot=1: same as oneshot=0.
//  - load, any state: count <= min(load_val, mod_last); no step, tc=0, state unchanged.
//  - Priority: rst_n > load > step. stop does not block load.
//  - mod_last=0 (modulus 1): count stays 0; every step is terminal.
//  - mod_last lowered below count mid-run: next step is terminal (up -> 0, down -> mod_last).
//  - IDLE and DONE: count holds, ce ignored, tc=0.
//  - Arithmetic is modulo 2**WIDTH and never overflows: term catches all-ones before +1.
//  - Latency: count, busy, done update one clock after the qualifying edge; tc has zero latency.
// CONFIGURATION
//  MODN_WRAP_CNT_EN defined:
//   - Adds port wrap_cnt out WCNT_W: number of tc events since reset.
//   - Saturates at all-ones; cleared only by rst_n (not by load, start or stop).
//  MODN_WRAP_CNT_EN undefined:
//   - No wrap_cnt port, no counter logic; all other behaviour identical.
// TESTING
//  1. rst_n=0 mid-RUN at count=5 -> count=0, busy=0, done=0 asynchronously, before the next clk edge.
//  2. WIDTH=8, mod_last=9, up=1, start then ce=1 for 12 cycles ->
//     count 1..9,0,1,2; tc=1 only on the cycle count==9.
//  3. mod_last=9, up=0, count=0, ce=1 -> count=9, tc=1; next step -> 8, tc=0.
//  4. oneshot=1, mod_last=3, up=1, start, ce=1 ->
//     count 1,2,3 then holds 3; done pulses once; busy=0; further ce ignored; start restarts from 3 (term -> DONE again).
//  5. load=1, load_val=200, mod_last=99, ce=1 same cycle -> count=99, tc=0.
//     Next up step -> 0, tc=1. Then start+stop together -> IDLE.
//  6. MODN_WRAP_CNT_EN, WCNT_W=2, mod_last=0, ce=1 for 6 steps ->
//     wrap_cnt 1,2,3,3,3,3; count stays 0.

Source files
------------

// File: rtl/modulo_n_updown.sv
// modulo_n_updown: run-time modulus up/down counter with load, start/stop, one-shot and tc cascade carry.
// count/busy/done registered (1 clk), tc combinational (0 clk); no backpressure, ce gates steps; MODN_WRAP_CNT_EN adds wrap_cnt.
module modulo_n_updown #(
  parameter int WIDTH = 8
`ifdef MODN_WRAP_CNT_EN
  ,
  parameter int WCNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              up,
  input  logic [WIDTH-1:0]  mod_last,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              start,
  input  logic              stop,
  input  logic              oneshot,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              busy,
  output logic              done
`ifdef MODN_WRAP_CNT_EN
  ,
  output logic [WCNT_W-1:0] wrap_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             term;
  logic             step;

  // Down-count treats an out-of-range count as terminal so a lowered mod_last recovers in one step.
  assign term = up ? (count >= mod_last) : ((count == '0) || (count > mod_last));
  assign step = (state == RUN) && ce && !load && !stop;
  assign tc   = step && term;

  always_comb begin
    state_nxt = state;
    count_nxt = count;

    if (stop) begin
      state_nxt = IDLE;
    end else if (start && (state != RUN)) begin
      state_nxt = RUN;
    end else if (tc && oneshot) begin
      state_nxt = DONE;
    end

    if (load) begin
      count_nxt = (load_val > mod_last) ? mod_last : load_val;
    end else if (step) begin
      if (term && oneshot) begin
        count_nxt = (!up && (count > mod_last)) ? mod_last : count;
      end else if (term) begin
        count_nxt = up ? '0 : mod_last;
      end else begin
        count_nxt = up ? (count + 1'b1) : (count - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE) && (state != DONE);
    end
  end

`ifdef MODN_WRAP_CNT_EN
  // Saturating tc event counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt <= '0;
    end else if (tc && (wrap_cnt != '1)) begin
      wrap_cnt <= wrap_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_modulo_n_updown.sv
// Randomized and directed bench for modulo_n_updown against a behavioural model.
module tb_modulo_n_updown;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce, up, load, start, stop, oneshot;
  logic [7:0] mod_last, load_val, count;
  logic       tc, busy, done;
`ifdef MODN_WRAP_CNT_EN
  logic [1:0] wrap_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  int m_count, m_st, m_wrap;
  bit m_busy, m_done;
  bit obs_tc;

  int exp2[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp6[6]  = '{1, 2, 3, 3, 3, 3};

  always #5 clk = ~clk;

  modulo_n_updown #(
    .WIDTH(8)
`ifdef MODN_WRAP_CNT_EN
    ,
    .WCNT_W(2)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .up       (up),
    .mod_last (mod_last),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .oneshot  (oneshot),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
`ifdef MODN_WRAP_CNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_st    = S_IDLE;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_wrap  = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_count"}, int'(count), m_count);
    check({tag, "_busy"}, int'(busy), int'(m_busy));
    check({tag, "_done"}, int'(done), int'(m_done));
`ifdef MODN_WRAP_CNT_EN
    check({tag, "_wrap"}, int'(wrap_cnt), m_wrap);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ce = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, check tc combinationally, advance model at posedge, check registers.
  task automatic cyc(input string tag, input bit c, input bit u, input int ml, input bit ld,
                     input int lv, input bit st, input bit sp, input bit os);
    bit step, term, wrapped;
    int nxt, ns;
    @(negedge clk);
    ce = c; up = u; mod_last = 8'(ml); load = ld; load_val = 8'(lv);
    start = st; stop = sp; oneshot = os;
    #1;
    step    = (m_st == S_RUN) && c && !ld && !sp;
    term    = u ? (m_count >= ml) : (m_count == 0 || m_count > ml);
    wrapped = step && term;
    obs_tc  = tc;
    check({tag, "_tc"}, int'(tc), int'(wrapped));

    if (ld)
      nxt = (lv < ml) ? lv : ml;
    else if (!step)
      nxt = m_count;
    else if (wrapped && os)
      nxt = (!u && m_count > ml) ? ml : m_count;
    else if (m_count > ml)
      nxt = u ? 0 : ml;
    else if (u)
      nxt = (m_count + 1) % (ml + 1);
    else
      nxt = (m_count + ml) % (ml + 1);

    if (sp)                          ns = S_IDLE;
    else if (st && m_st != S_RUN)    ns = S_RUN;
    else if (wrapped && os)          ns = S_DONE;
    else                             ns = m_st;

    @(posedge clk);
    #1;
    m_done  = (ns == S_DONE) && (m_st != S_DONE);
    m_busy  = (ns == S_RUN);
    m_st    = ns;
    m_count = nxt;
    if (wrapped && m_wrap < 3) m_wrap++;
    check_regs(tag);
  endtask

  initial begin
    int ml;
    rst_n = 1'b0;
    ce = 1'b0; up = 1'b1; mod_last = 8'd0; load = 1'b0; load_val = 8'd0;
    start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("rst");
    check("rst_tc", int'(tc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous up count, modulus 10
    cyc("t2_start", 0, 1, 9, 0, 0, 1, 0, 0);
    check("t2_busy", int'(busy), 1);
    for (int i = 0; i < 12; i++) begin
      cyc("t2", 1, 1, 9, 0, 0, 0, 0, 0);
      check("t2_seq", int'(count), exp2[i]);
      check("t2_tcseq", int'(obs_tc), int'(i == 9));
    end

    // Asynchronous reset mid-run at count 5
    repeat (3) cyc("t1_run", 1, 1, 9, 0, 0, 0, 0, 0);
    check("t1_pre", int'(count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_count", int'(count), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_done", int'(done), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Down count wraps from 0 to mod_last
    cyc("t3_start", 0, 0, 9, 0, 0, 1, 0, 0);
    cyc("t3_wrap", 1, 0, 9, 0, 0, 0, 0, 0);
    check("t3_cnt9", int'(count), 9);
    check("t3_tc1", int'(obs_tc), 1);
    cyc("t3_next", 1, 0, 9, 0, 0, 0, 0, 0);
    check("t3_cnt8", int'(count), 8);
    check("t3_tc0", int'(obs_tc), 0);

    // One-shot up to 3, then restart
    do_reset();
    cyc("t4_start", 0, 1, 3, 0, 0, 1, 0, 1);
    repeat (3) cyc("t4_run", 1, 1, 3, 0, 0, 0, 0, 1);
    check("t4_cnt3", int'(count), 3);
    cyc("t4_term", 1, 1, 3, 0, 0, 0, 0, 1);
    check("t4_hold", int'(count), 3);
    check("t4_donepulse", int'(done), 1);
    check("t4_idlebusy", int'(busy), 0);
    cyc("t4_ign", 1, 1, 3, 0, 0, 0, 0, 1);
    check("t4_doneclr", int'(done), 0);
    check("t4_ign_tc", int'(obs_tc), 0);
    cyc("t4_restart", 0, 1, 3, 0, 0, 1, 0, 1);
    check("t4_rebusy", int'(busy), 1);
    cyc("t4_reterm", 1, 1, 3, 0, 0, 0, 0, 1);
    check("t4_redone", int'(done), 1);
    check("t4_recnt", int'(count), 3);

    // Load clamp, wrap after load, stop beats start
    do_reset();
    cyc("t5_start", 0, 1, 99, 0, 0, 1, 0, 0);
    cyc("t5_load", 1, 1, 99, 1, 200, 0, 0, 0);
    check("t5_clamp", int'(count), 99);
    check("t5_ldtc", int'(obs_tc), 0);
    cyc("t5_wrap", 1, 1, 99, 0, 0, 0, 0, 0);
    check("t5_zero", int'(count), 0);
    check("t5_tc", int'(obs_tc), 1);
    cyc("t5_stopwin", 0, 1, 99, 0, 0, 1, 1, 0);
    check("t5_idle", int'(busy), 0);

`ifdef MODN_WRAP_CNT_EN
    // Modulus 1: every step terminal, wrap_cnt saturates at 3
    do_reset();
    cyc("t6_start", 0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc("t6", 1, 1, 0, 0, 0, 0, 0, 0);
      check("t6_wrap", int'(wrap_cnt), exp6[i]);
      check("t6_cnt", int'(count), 0);
    end
`endif

    // Randomized traffic including mid-run modulus changes and full-range modulus
    do_reset();
    ml = 7;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0)
        ml = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      cyc("rnd",
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          ml,
          $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 255)),
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
